sevenseg_scan_decoder: RTL and testbench
========================================

// Module: sevenseg_scan_decoder
// PURPOSE
//  Reverse of the hex-to-seven-segment encoder. Watches a multiplexed display bus
//  (one-hot digit strobes + shared segment lines) and recovers each digit's 4-bit value.
//  Tolerates glitches by requiring repeated identical samples before committing a digit.
//  Sits beside the display driver as a loopback checker and self-test monitor.
// PARAMETERS
//  NDIG    4  number of multiplexed digits (2..8)
//  SETTLE  4  cycles a strobe must be steady before its segments are sampled (1..255)
//  STABLE  3  identical consecutive samples of a digit required to commit it (1..15)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high
//  an          in   NDIG    digit strobes, active-high, legal when one-hot
//  segments    in   7       {g,f,e,d,c,b,a}, active-high, bit0 = a
//  digits      out  4*NDIG  committed value; digit i at [4i+3:4i]
//  dig_valid   out  NDIG    committed pattern is a hex glyph
//  dig_blank   out  NDIG    committed pattern is 7'b0000000
//  dig_err     out  NDIG    committed pattern is not a glyph and not blank
//  update      out  1       1-cycle pulse: some committed digit changed value or kind
//  glitch      out  1       1-cycle pulse: an went from one-hot to not-one-hot
// BEHAVIOUR
//  - Reset: digits=0, dig_valid=0, dig_blank=0, dig_err=0, update=0, glitch=0.
//    Reset also clears the settle counter and all per-digit history/match counts.
//  - Settle: counter clears when an changes or an is not one-hot; else saturating increment.
//    Sample cycle = the cycle in which the same one-hot an has held SETTLE consecutive
//    cycles, counting that cycle. Exactly one sample per dwell, with no resample until an changes.
//  - Per digit i (the only digit sampled is the one whose strobe is high): keep last pattern and match count.
//    Sample==last -> count sat-inc to STABLE; else last<=sample, count<=1.
//  - Commit: in the sample cycle where the new count equals STABLE, write digit/kind regs.
//    Outputs are visible the next cycle. Sampling further identical patterns while the count
//    is saturated does not re-commit.
//  - Kind decode (sample -> code):
//    0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101
//    7=0000111 8=1111111 9=1101111 A=1110111 b=1111100 C=0111001 d=1011110
//    E=1111001 F=1110001.
//    0000000 -> blank with code 0. Any other pattern -> err with code 0.
//    Exactly one of valid/blank/err is high per digit after its first commit.
//  - update: pulses in the cycle the committed regs change, only if value or kind differs.
//    A commit that rewrites identical contents does not pulse.
//  - glitch: pulses one cycle after the first non-one-hot cycle following a one-hot cycle.
//    A non-one-hot an produces no sample; history is kept.
//  - Dwell cut short by an change before SETTLE: no sample, history untouched.
//  - Reset mid-dwell or mid-match: everything returns to reset state. The first post-reset
//    commit always pulses update.
// STRUCTURE
//  - sevenseg_pkg: SEG_* glyph constants (16 patterns + SEG_BLANK), enum
//    seg_kind_t {KIND_NONE, KIND_HEX, KIND_BLANK, KIND_ERR}.
//  - Sub-module sevenseg_glyph_decode: combinational segments -> {code[3:0], seg_kind_t}.
//  - Top: settle counter, one-hot check + index encoder, generate loop of per-digit
//    history/match/commit registers.
// TESTING (NDIG=4, SETTLE=4, STABLE=3)
//  1 Reset with an=0001, segments=1001111 held -> all outputs 0, no update for any cycle.
//  2 Scan an 0001..1000, 8 cycles each; digit0=1001111, others 0111111; 3 full rounds
//    -> digits=16'h0003, dig_valid=1111, update pulses exactly once per digit, in round 3.
//  3 After test 2, digit0 gets 1011011 in one round then 1001111 -> no commit, digits stay
//    16'h0003, no update.
//  4 Digit2 gets 1000000 for 3 rounds -> dig_err[2]=1, dig_valid[2]=0, digit2 code 0,
//    one update pulse. Then 0000000 for 3 rounds -> dig_blank[2]=1, one pulse.
//  5 Strobes held 3 cycles each (< SETTLE) -> no samples, no commits. Inject an=0011 for one
//    cycle -> glitch pulses once, no sample.
//  6 Assert reset after 2 matching rounds of a new value -> all regs cleared. After release,
//    3 rounds are needed before commit, and update pulses.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared glyph table and decode result types for the seven-segment scan decoder.
// Segment ordering is {g,f,e,d,c,b,a}, with bit 0 driving segment a.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_HEX,
        KIND_BLANK,
        KIND_ERR
    } seg_kind_t;

    typedef struct packed {
        logic [3:0] code;
        seg_kind_t  kind;
    } glyph_t;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Entry k holds the glyph for hex value k.
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational reverse lookup: a segment pattern becomes a hex code plus its kind.
// Blank and unrecognised patterns both report code 0.
module sevenseg_glyph_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] segments_i,
    output glyph_t     glyph_o
);

    // NOTE: every output gets a default before the search so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        glyph_o.code = 4'd0;
        glyph_o.kind = KIND_ERR;
        if (segments_i == SEG_BLANK) begin
            glyph_o.kind = KIND_BLANK;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (segments_i == SEG_GLYPHS[k]) begin
                    glyph_o.code = 4'(k);
                    glyph_o.kind = KIND_HEX;
                end
            end
        end
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Monitors a multiplexed seven-segment bus and recovers each digit's committed value,
// sampling once per settled strobe dwell and committing after STABLE identical samples.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int SETTLE = 4,
    parameter int STABLE = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NDIG-1:0]     an,
    input  logic [6:0]          segments,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     dig_valid,
    output logic [NDIG-1:0]     dig_blank,
    output logic [NDIG-1:0]     dig_err,
    output logic                update,
    output logic                glitch
);

    localparam int         IW       = $clog2(NDIG);
    localparam logic [7:0] SETTLE_C = 8'(SETTLE);
    localparam logic [3:0] STABLE_C = 4'(STABLE);

    logic [NDIG-1:0] an_q;
    logic [7:0]      settle_q, settle_d;
    logic            onehot, onehot_q, same_an;
    logic            sample;
    logic [IW-1:0]   idx;
    logic            glitch_q, update_q;
    logic [NDIG-1:0] changed;
    glyph_t          glyph;

    sevenseg_glyph_decode u_decode (
        .segments_i (segments),
        .glyph_o    (glyph)
    );

    // settle_d is the length of the current one-hot dwell, counting this cycle.
    always_comb begin
        onehot  = (an != '0) && ((an & (an - NDIG'(1))) == '0);
        same_an = onehot && (an == an_q);
        if (!onehot) begin
            settle_d = 8'd0;
        end else if (!same_an) begin
            settle_d = 8'd1;
        end else if (settle_q == SETTLE_C) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + 8'd1;
        end
        sample = onehot && (settle_d == SETTLE_C) && !(same_an && (settle_q == SETTLE_C));
    end

    always_comb begin
        idx = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (an[k]) begin
                idx = IW'(k);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the statements are written in.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q     <= '0;
            settle_q <= 8'd0;
            onehot_q <= 1'b0;
            glitch_q <= 1'b0;
            update_q <= 1'b0;
        end else begin
            an_q     <= an;
            settle_q <= settle_d;
            onehot_q <= onehot;
            glitch_q <= onehot_q && !onehot;
            update_q <= |changed;
        end
    end

    assign update = update_q;
    assign glitch = glitch_q;

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        logic [6:0] last_q;
        logic [3:0] match_q, match_d;
        logic [3:0] code_q;
        seg_kind_t  kind_q;
        logic       hit, is_match, commit;

        assign hit      = sample && (idx == IW'(i));
        assign is_match = (segments == last_q);
        assign match_d  = !is_match            ? 4'd1 :
                          (match_q == STABLE_C) ? match_q : match_q + 4'd1;
        // A saturated count seeing the same pattern again must not re-commit.
        assign commit   = hit && (match_d == STABLE_C) && !(is_match && (match_q == STABLE_C));
        assign changed[i] = commit && ((glyph.code != code_q) || (glyph.kind != kind_q));

        // NOTE: the per-digit history is reset too, so a reset mid-match forces a
        // fresh run of STABLE samples and the first commit always differs from KIND_NONE.
        always_ff @(posedge clk) begin
            if (reset) begin
                last_q  <= SEG_BLANK;
                match_q <= 4'd0;
                code_q  <= 4'd0;
                kind_q  <= KIND_NONE;
            end else if (hit) begin
                last_q  <= segments;
                match_q <= match_d;
                if (commit) begin
                    code_q <= glyph.code;
                    kind_q <= glyph.kind;
                end
            end
        end

        assign digits[4*i +: 4] = code_q;
        assign dig_valid[i]     = (kind_q == KIND_HEX);
        assign dig_blank[i]     = (kind_q == KIND_BLANK);
        assign dig_err[i]       = (kind_q == KIND_ERR);
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for the scan decoder: scans a 4-digit bus with fixed dwell lengths
// and compares committed state and pulse counts against hand-worked values.
module tb_sevenseg_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  segments;
    logic [15:0] digits;
    logic [3:0]  dig_valid, dig_blank, dig_err;
    logic        update, glitch;

    int checks = 0;
    int errors = 0;
    int upd_total, glitch_total;
    int upd_dig [4];

    localparam logic [6:0] P0   = 7'b0111111;
    localparam logic [6:0] P2   = 7'b1011011;
    localparam logic [6:0] P3   = 7'b1001111;
    localparam logic [6:0] P4   = 7'b1100110;
    localparam logic [6:0] P8   = 7'b1111111;
    localparam logic [6:0] PERR = 7'b1000000;
    localparam logic [6:0] PBLK = 7'b0000000;

    sevenseg_scan_decoder #(.NDIG(4), .SETTLE(4), .STABLE(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .an        (an),
        .segments  (segments),
        .digits    (digits),
        .dig_valid (dig_valid),
        .dig_blank (dig_blank),
        .dig_err   (dig_err),
        .update    (update),
        .glitch    (glitch)
    );

    always #5 clk = ~clk;

    task automatic clear_counts();
        upd_total    = 0;
        glitch_total = 0;
        for (int i = 0; i < 4; i++) upd_dig[i] = 0;
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int c = 0; c < n; c++) begin
            an       = a;
            segments = s;
            @(posedge clk);
            #1;
            if (update === 1'b1) begin
                upd_total++;
                for (int i = 0; i < 4; i++) if (a[i]) upd_dig[i]++;
            end
            if (glitch === 1'b1) glitch_total++;
        end
    endtask

    task automatic scan_round(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input int n);
        dwell(4'b0001, s0, n);
        dwell(4'b0010, s1, n);
        dwell(4'b0100, s2, n);
        dwell(4'b1000, s3, n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_counts();
        dwell(4'b0001, P3, 6);
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want %h", digits, 16'h0000); end
        checks++; if (dig_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want %b", dig_valid, 4'b0000); end
        checks++; if (dig_blank !== 4'b0000) begin errors++; $display("FAIL reset_blank got %b want %b", dig_blank, 4'b0000); end
        checks++; if (dig_err !== 4'b0000) begin errors++; $display("FAIL reset_err got %b want %b", dig_err, 4'b0000); end
        checks++; if (upd_total != 0) begin errors++; $display("FAIL reset_update got %0d want 0", upd_total); end
        checks++; if (glitch_total != 0) begin errors++; $display("FAIL reset_glitch got %0d want 0", glitch_total); end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        clear_counts();
        scan_round(P3, P0, P0, P0, 8);
        scan_round(P3, P0, P0, P0, 8);
        checks++; if (upd_total != 0) begin errors++; $display("FAIL scan_early_update got %0d want 0", upd_total); end
        checks++; if (dig_valid !== 4'b0000) begin errors++; $display("FAIL scan_early_valid got %b want %b", dig_valid, 4'b0000); end
        scan_round(P3, P0, P0, P0, 8);
        for (int i = 0; i < 4; i++) begin
            checks++; if (upd_dig[i] != 1) begin errors++; $display("FAIL scan_update_digit%0d got %0d want 1", i, upd_dig[i]); end
        end
        checks++; if (upd_total != 4) begin errors++; $display("FAIL scan_update_total got %0d want 4", upd_total); end
        checks++; if (digits !== 16'h0003) begin errors++; $display("FAIL scan_digits got %h want %h", digits, 16'h0003); end
        checks++; if (dig_valid !== 4'b1111) begin errors++; $display("FAIL scan_valid got %b want %b", dig_valid, 4'b1111); end
        checks++; if ((dig_blank | dig_err) !== 4'b0000) begin errors++; $display("FAIL scan_blank_err got %b want %b", dig_blank | dig_err, 4'b0000); end
        checks++; if (glitch_total != 0) begin errors++; $display("FAIL scan_glitch got %0d want 0", glitch_total); end
    endtask

    task automatic test_no_commit();
        clear_counts();
        scan_round(P2, P0, P0, P0, 8);
        scan_round(P3, P0, P0, P0, 8);
        checks++; if (digits !== 16'h0003) begin errors++; $display("FAIL flicker_digits got %h want %h", digits, 16'h0003); end
        checks++; if (upd_total != 0) begin errors++; $display("FAIL flicker_update got %0d want 0", upd_total); end
        // Two more rounds re-commit the identical value 3: no pulse expected.
        scan_round(P3, P0, P0, P0, 8);
        scan_round(P3, P0, P0, P0, 8);
        checks++; if (upd_total != 0) begin errors++; $display("FAIL recommit_update got %0d want 0", upd_total); end
        checks++; if (digits !== 16'h0003) begin errors++; $display("FAIL recommit_digits got %h want %h", digits, 16'h0003); end
    endtask

    task automatic test_kinds();
        clear_counts();
        for (int r = 0; r < 3; r++) scan_round(P3, P0, PERR, P0, 8);
        checks++; if (upd_total != 1) begin errors++; $display("FAIL err_update got %0d want 1", upd_total); end
        checks++; if (upd_dig[2] != 1) begin errors++; $display("FAIL err_update_digit2 got %0d want 1", upd_dig[2]); end
        checks++; if (dig_err !== 4'b0100) begin errors++; $display("FAIL err_flag got %b want %b", dig_err, 4'b0100); end
        checks++; if (dig_valid !== 4'b1011) begin errors++; $display("FAIL err_valid got %b want %b", dig_valid, 4'b1011); end
        checks++; if (digits !== 16'h0003) begin errors++; $display("FAIL err_digits got %h want %h", digits, 16'h0003); end
        clear_counts();
        for (int r = 0; r < 3; r++) scan_round(P3, P0, PBLK, P0, 8);
        checks++; if (upd_total != 1) begin errors++; $display("FAIL blank_update got %0d want 1", upd_total); end
        checks++; if (dig_blank !== 4'b0100) begin errors++; $display("FAIL blank_flag got %b want %b", dig_blank, 4'b0100); end
        checks++; if (dig_err !== 4'b0000) begin errors++; $display("FAIL blank_err got %b want %b", dig_err, 4'b0000); end
        checks++; if (dig_valid !== 4'b1011) begin errors++; $display("FAIL blank_valid got %b want %b", dig_valid, 4'b1011); end
        checks++; if (digits !== 16'h0003) begin errors++; $display("FAIL blank_digits got %h want %h", digits, 16'h0003); end
    endtask

    task automatic test_short_dwell_glitch();
        clear_counts();
        for (int r = 0; r < 4; r++) scan_round(P3, P4, PBLK, P4, 3);
        checks++; if (upd_total != 0) begin errors++; $display("FAIL short_update got %0d want 0", upd_total); end
        checks++; if (digits !== 16'h0003) begin errors++; $display("FAIL short_digits got %h want %h", digits, 16'h0003); end
        checks++; if (glitch_total != 0) begin errors++; $display("FAIL short_glitch got %0d want 0", glitch_total); end
        clear_counts();
        dwell(4'b0011, P4, 1);
        checks++; if (glitch !== 1'b1) begin errors++; $display("FAIL glitch_pulse got %b want 1", glitch); end
        dwell(4'b0010, P4, 3);
        checks++; if (glitch_total != 1) begin errors++; $display("FAIL glitch_count got %0d want 1", glitch_total); end
        checks++; if (upd_total != 0) begin errors++; $display("FAIL glitch_update got %0d want 0", upd_total); end
        checks++; if (digits !== 16'h0003) begin errors++; $display("FAIL glitch_digits got %h want %h", digits, 16'h0003); end
    endtask

    task automatic test_reset_mid_match();
        clear_counts();
        scan_round(P3, P0, P0, P8, 8);
        scan_round(P3, P0, P0, P8, 8);
        dwell(4'b0001, P3, 2);
        reset = 1'b1;
        dwell(4'b0001, P3, 3);
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL rst2_digits got %h want %h", digits, 16'h0000); end
        checks++; if ((dig_valid | dig_blank | dig_err) !== 4'b0000) begin errors++; $display("FAIL rst2_kinds got %b want %b", dig_valid | dig_blank | dig_err, 4'b0000); end
        checks++; if (upd_total != 0) begin errors++; $display("FAIL rst2_update got %0d want 0", upd_total); end
        reset = 1'b0;
        clear_counts();
        scan_round(P3, P0, P0, P8, 8);
        scan_round(P3, P0, P0, P8, 8);
        checks++; if (upd_total != 0) begin errors++; $display("FAIL post_rst_early_update got %0d want 0", upd_total); end
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL post_rst_early_digits got %h want %h", digits, 16'h0000); end
        scan_round(P3, P0, P0, P8, 8);
        checks++; if (upd_total != 4) begin errors++; $display("FAIL post_rst_update got %0d want 4", upd_total); end
        checks++; if (digits !== 16'h8003) begin errors++; $display("FAIL post_rst_digits got %h want %h", digits, 16'h8003); end
        checks++; if (dig_valid !== 4'b1111) begin errors++; $display("FAIL post_rst_valid got %b want %b", dig_valid, 4'b1111); end
    endtask

    initial begin
        reset    = 1'b1;
        an       = 4'b0001;
        segments = P3;
        test_reset();
        test_scan();
        test_no_commit();
        test_kinds();
        test_short_dwell_glitch();
        test_reset_mid_match();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
